output_dispatch_block: RTL and testbench

//  Clocked router-output stage: accepts 11-bit flits on one 4-phase bundled-data input

---
 rtl/noc_pkg.sv | 26 ++
 rtl/dispatch_out_port.sv | 97 +++++++++
 rtl/output_dispatch_block.sv | 102 ++++++++++
 tb/tb_output_dispatch_block.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared types and constants for the router output-dispatch stage.
// Flit layout is {dest, src, payload}.
package noc_pkg;

  localparam int unsigned NUM_PORTS = 4;
  localparam int unsigned DEST_MSB  = 10;
  localparam int unsigned DEST_LSB  = 9;

  typedef struct packed {
    logic [1:0] dest;
    logic [1:0] src;
    logic [6:0] payload;
  } flit_t;

  typedef enum logic {
    InIdle,
    InAck
  } in_state_e;

  typedef enum logic [1:0] {
    OIdle,
    OReq,
    ORel
  } out_state_e;

endpackage

// File: rtl/dispatch_out_port.sv
// One output port: small flit FIFO, 4-phase output handshake FSM and a
// counter of flits fully delivered on this port.
module dispatch_out_port
  import noc_pkg::*;
#(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic             full_o,
  output logic             out_req_o,
  output logic [WIDTH-1:0] out_data_o,
  input  logic             out_ack_i,
  output logic [CNT_W-1:0] pkt_cnt_o
);

  localparam int unsigned AddrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AddrW:0]   wr_ptr_q, rd_ptr_q;
  logic             empty, pop, do_push;

  out_state_e       state_q, state_d;
  logic             out_req_q, out_req_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Extra wrap bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]) &&
                   (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]);
  assign do_push = push_i && !full_o;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AddrW-1:0]] <= push_data_i;
    end
  end

  always_comb begin
    state_d    = state_q;
    out_req_d  = out_req_q;
    out_data_d = out_data_q;
    cnt_d      = cnt_q;
    pop        = 1'b0;
    unique case (state_q)
      OIdle: begin
        if (!empty) begin
          out_data_d = mem_q[rd_ptr_q[AddrW-1:0]];
          out_req_d  = 1'b1;
          state_d    = OReq;
        end
      end
      OReq: begin
        if (out_ack_i) begin
          out_req_d = 1'b0;
          pop       = 1'b1;
          cnt_d     = cnt_q + 1'b1;
          state_d   = ORel;
        end
      end
      ORel: begin
        if (!out_ack_i) begin
          state_d = OIdle;
        end
      end
      default: state_d = OIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      state_q    <= OIdle;
      out_req_q  <= 1'b0;
      out_data_q <= '0;
      cnt_q      <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      state_q    <= state_d;
      out_req_q  <= out_req_d;
      out_data_q <= out_data_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_req_o  = out_req_q;
  assign out_data_o = out_data_q;
  assign pkt_cnt_o  = cnt_q;

endmodule

// File: rtl/output_dispatch_block.sv
// Splits one 4-phase flit stream into four buffered output ports by dest field,
// reporting the dest of every accepted flit on a side handshake channel.
module output_dispatch_block
  import noc_pkg::*;
#(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                in_req_i,
  input  logic [WIDTH-1:0]                    in_data_i,
  output logic                                in_ack_o,
  output logic [NUM_PORTS-1:0]                out_req_o,
  output logic [NUM_PORTS-1:0][WIDTH-1:0]     out_data_o,
  input  logic [NUM_PORTS-1:0]                out_ack_i,
  output logic                                route_req_o,
  output logic [1:0]                          route_data_o,
  input  logic                                route_ack_i,
  output logic [NUM_PORTS-1:0][CNT_W-1:0]     pkt_cnt_o
);

  in_state_e            in_state_q, in_state_d;
  logic                 in_ack_q, in_ack_d;
  logic                 route_req_q, route_req_d;
  logic [1:0]           route_data_q, route_data_d;
  logic [1:0]           dest;
  logic [NUM_PORTS-1:0] full, push;
  logic                 accept;

  assign dest   = in_data_i[DEST_MSB:DEST_LSB];
  // Each accept needs a free slot at its port and a fully idle route-report channel.
  assign accept = (in_state_q == InIdle) && in_req_i && !full[dest] &&
                  !route_req_q && !route_ack_i;

  always_comb begin
    in_state_d   = in_state_q;
    in_ack_d     = in_ack_q;
    route_req_d  = route_req_q;
    route_data_d = route_data_q;
    push         = '0;
    if (route_req_q && route_ack_i) begin
      route_req_d = 1'b0;
    end
    unique case (in_state_q)
      InIdle: begin
        if (accept) begin
          push[dest]   = 1'b1;
          route_data_d = dest;
          route_req_d  = 1'b1;
          in_ack_d     = 1'b1;
          in_state_d   = InAck;
        end
      end
      InAck: begin
        if (!in_req_i) begin
          in_ack_d   = 1'b0;
          in_state_d = InIdle;
        end
      end
      default: in_state_d = InIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      in_state_q   <= InIdle;
      in_ack_q     <= 1'b0;
      route_req_q  <= 1'b0;
      route_data_q <= '0;
    end else begin
      in_state_q   <= in_state_d;
      in_ack_q     <= in_ack_d;
      route_req_q  <= route_req_d;
      route_data_q <= route_data_d;
    end
  end

  assign in_ack_o     = in_ack_q;
  assign route_req_o  = route_req_q;
  assign route_data_o = route_data_q;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    dispatch_out_port #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
    ) u_port (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .push_i      (push[p]),
      .push_data_i (in_data_i),
      .full_o      (full[p]),
      .out_req_o   (out_req_o[p]),
      .out_data_o  (out_data_o[p]),
      .out_ack_i   (out_ack_i[p]),
      .pkt_cnt_o   (pkt_cnt_o[p])
    );
  end

endmodule

// File: tb/tb_output_dispatch_block.sv
// Randomised and directed bench for output_dispatch_block, checked every cycle
// against a queue-based model of the handshake and buffering rules.
module tb_output_dispatch_block;

  localparam int unsigned W  = 11;
  localparam int unsigned D  = 2;
  localparam int unsigned CW = 16;
  localparam int unsigned NP = 4;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic                  in_req = 1'b0;
  logic [W-1:0]          in_data = '0;
  logic                  in_ack;
  logic [NP-1:0]         out_req;
  logic [NP-1:0][W-1:0]  out_data;
  logic [NP-1:0]         out_ack = '0;
  logic                  route_req;
  logic [1:0]            route_data;
  logic                  route_ack = 1'b0;
  logic [NP-1:0][CW-1:0] pkt_cnt;

  always #5 clk = ~clk;

  output_dispatch_block #(
    .WIDTH (W),
    .DEPTH (D),
    .CNT_W (CW)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .in_req_i     (in_req),
    .in_data_i    (in_data),
    .in_ack_o     (in_ack),
    .out_req_o    (out_req),
    .out_data_o   (out_data),
    .out_ack_i    (out_ack),
    .route_req_o  (route_req),
    .route_data_o (route_data),
    .route_ack_i  (route_ack),
    .pkt_cnt_o    (pkt_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Model: flits accepted but not yet delivered, per port, oldest first.
  logic [W-1:0] exp_q [NP][$];
  int           model_cnt [NP];
  int           sent_tally [NP];
  int           acc_total;
  bit           seen_req [NP];

  bit block [NP];
  bit route_hold;
  int max_dly;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mk(input int dst, input int src, input int pay);
    logic [1:0] d2, s2;
    logic [6:0] p7;
    d2 = dst[1:0];
    s2 = src[1:0];
    p7 = pay[6:0];
    return {d2, s2, p7};
  endfunction

  // Previous-cycle samples: what the DUT saw at the edge just taken.
  logic                 p_in_req, p_in_ack, p_rr, p_ra;
  logic [W-1:0]         p_in_data;
  logic [NP-1:0]        p_oreq, p_oack;
  logic [NP-1:0][W-1:0] p_odata;
  logic [1:0]           c_dst;
  bit                   c_acc;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int p = 0; p < NP; p++) begin
          exp_q[p].delete();
          model_cnt[p] = 0;
          seen_req[p]  = 1'b0;
        end
        chk("rst_in_ack", in_ack, 0);
        chk("rst_out_req", out_req, 0);
        chk("rst_route_req", route_req, 0);
        chk("rst_pkt_cnt", |pkt_cnt, 0);
      end else begin
        c_dst = p_in_data[10:9];
        c_acc = !p_in_ack && p_in_req && (exp_q[c_dst].size() < D) && !p_rr && !p_ra;
        chk("in_ack", in_ack, p_in_ack ? p_in_req : c_acc);
        chk("route_req", route_req, c_acc ? 1'b1 : (p_rr && !p_ra));
        if (c_acc) chk("route_data", route_data, c_dst);
        for (int p = 0; p < NP; p++) begin
          if (p_oreq[p]) begin
            if (p_oack[p]) begin
              chk("out_req_fall", out_req[p], 0);
              if (exp_q[p].size() != 0) void'(exp_q[p].pop_front());
              model_cnt[p]++;
            end else begin
              chk("out_req_hold", out_req[p], 1);
              chk("out_data_hold", out_data[p], p_odata[p]);
            end
          end else if (out_req[p]) begin
            seen_req[p] = 1'b1;
            chk("out_req_rise_nonempty", exp_q[p].size() != 0, 1);
            if (exp_q[p].size() != 0) chk("out_data_head", out_data[p], exp_q[p][0]);
          end else begin
            chk("out_data_stable", out_data[p], p_odata[p]);
          end
        end
        if (c_acc) begin
          exp_q[c_dst].push_back(p_in_data);
          acc_total++;
        end
        for (int p = 0; p < NP; p++) chk("pkt_cnt", pkt_cnt[p], model_cnt[p] % 65536);
      end
      p_in_req  = in_req;
      p_in_ack  = in_ack;
      p_in_data = in_data;
      p_rr      = route_req;
      p_ra      = route_ack;
      p_oreq    = out_req;
      p_oack    = out_ack;
      p_odata   = out_data;
    end
  end

  // Sinks for the four output ports and the route-report channel.
  initial begin
    int sdly [NP];
    int rdly;
    rdly = 0;
    for (int p = 0; p < NP; p++) sdly[p] = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++) begin
        if (!rst_n) begin
          out_ack[p] = 1'b0;
          sdly[p] = 0;
        end else if (!out_ack[p] && out_req[p] && !block[p]) begin
          if (sdly[p] > 0) sdly[p]--;
          else begin
            out_ack[p] = 1'b1;
            sdly[p] = (max_dly == 0) ? 0 : int'($urandom_range(max_dly, 0));
          end
        end else if (out_ack[p] && !out_req[p]) begin
          out_ack[p] = 1'b0;
        end
      end
      if (!rst_n) begin
        route_ack = 1'b0;
        rdly = 0;
      end else if (!route_ack && route_req && !route_hold) begin
        if (rdly > 0) rdly--;
        else begin
          route_ack = 1'b1;
          rdly = (max_dly == 0) ? 0 : int'($urandom_range(max_dly, 0));
        end
      end else if (route_ack && !route_req) begin
        route_ack = 1'b0;
      end
    end
  end

  task automatic send(input logic [W-1:0] f);
    int n;
    @(posedge clk);
    #1;
    in_data = f;
    in_req  = 1'b1;
    n = 0;
    while (!in_ack && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("send_accept", in_ack, 1);
    if (in_ack) sent_tally[f[10:9]]++;
    in_req = 1'b0;
    n = 0;
    while (in_ack && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("send_release", in_ack, 0);
  endtask

  function automatic bit busy();
    bit b;
    b = in_req || in_ack || route_req || route_ack || (|out_req) || (|out_ack);
    for (int p = 0; p < NP; p++) if (exp_q[p].size() != 0) b = 1'b1;
    return b;
  endfunction

  task automatic drain(input string name);
    int n;
    n = 0;
    while (busy() && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk(name, busy(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n  = 1'b0;
    in_req = 1'b0;
    acc_total = 0;
    for (int p = 0; p < NP; p++) begin
      sent_tally[p] = 0;
      block[p] = 1'b0;
    end
    route_hold = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] f;
    max_dly = 0;
    acc_total = 0;
    route_hold = 1'b0;
    for (int p = 0; p < NP; p++) begin
      block[p] = 1'b0;
      sent_tally[p] = 0;
    end
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single flit to port 3.
    send(11'h612);
    drain("t1_drain");
    chk("t1_seen3", seen_req[3], 1);
    chk("t1_seen0", seen_req[0] | seen_req[1] | seen_req[2], 0);
    chk("t1_data3", out_data[3], 11'h612);
    chk("t1_route", route_data, 2'd3);
    chk("t1_cnt3", pkt_cnt[3], 1);
    chk("t1_cnt0", pkt_cnt[0], 0);

    // One flit to each port.
    do_reset();
    for (int p = 0; p < NP; p++) send(mk(p, 3 - p, 16 * p + 5));
    drain("t2_drain");
    for (int p = 0; p < NP; p++) chk("t2_cnt", pkt_cnt[p], 1);
    chk("t2_data2", out_data[2], 11'h4A5);

    // Port 1 sink stalled: third flit must wait for the first pop.
    do_reset();
    block[1] = 1'b1;
    fork
      begin
        send(mk(1, 0, 7'h11));
        send(mk(1, 0, 7'h22));
        send(mk(1, 0, 7'h33));
      end
      begin
        repeat (14) @(posedge clk);
        #1;
        chk("t3_acc", acc_total, 2);
        chk("t3_stall", {in_req, in_ack}, 2'b10);
        chk("t3_head", out_data[1], 11'h211);
        block[1] = 1'b0;
      end
    join
    drain("t3_drain");
    chk("t3_cnt1", pkt_cnt[1], 3);

    // Head-of-line: port-2 flit stuck behind a stalled port-1 flit.
    do_reset();
    block[1] = 1'b1;
    fork
      begin
        send(mk(1, 2, 7'h01));
        send(mk(1, 2, 7'h02));
        send(mk(1, 2, 7'h03));
        send(mk(2, 2, 7'h04));
      end
      begin
        repeat (16) @(posedge clk);
        #1;
        chk("t4_acc", acc_total, 2);
        chk("t4_req2", out_req[2], 0);
        chk("t4_cnt2", pkt_cnt[2], 0);
        block[1] = 1'b0;
      end
    join
    drain("t4_drain");
    chk("t4_cnt1", pkt_cnt[1], 3);
    chk("t4_cnt2b", pkt_cnt[2], 1);
    chk("t4_data2", out_data[2], 11'h504);

    // Route report withheld: no second accept.
    do_reset();
    route_hold = 1'b1;
    fork
      begin
        send(mk(0, 1, 7'h40));
        send(mk(2, 1, 7'h41));
      end
      begin
        repeat (10) @(posedge clk);
        #1;
        chk("t5_acc", acc_total, 1);
        chk("t5_rreq", route_req, 1);
        chk("t5_rdata", route_data, 0);
        route_hold = 1'b0;
      end
    join
    drain("t5_drain");
    chk("t5_cnt0", pkt_cnt[0], 1);
    chk("t5_cnt2", pkt_cnt[2], 1);
    chk("t5_rdata2", route_data, 2);

    // Reset while ports 0 and 2 hold undelivered flits.
    do_reset();
    block[0] = 1'b1;
    block[2] = 1'b1;
    send(mk(2, 0, 7'h55));
    send(mk(0, 0, 7'h66));
    repeat (4) @(posedge clk);
    #3;
    chk("t6_pre", {out_req[2], out_req[0]}, 2'b11);
    rst_n = 1'b0;
    #1;
    chk("t6_drop", {in_ack, route_req, out_req}, 0);
    block[0] = 1'b0;
    block[2] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("t6_nostale", {seen_req[0], seen_req[1], seen_req[2], seen_req[3]}, 0);
    chk("t6_cnt", |pkt_cnt, 0);

    // Random traffic with random sink and route delays.
    do_reset();
    max_dly = 6;
    for (int i = 0; i < 150; i++) begin
      f = mk(int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
             int'($urandom_range(127, 0)));
      send(f);
    end
    drain("rand_drain");
    for (int p = 0; p < NP; p++) chk("rand_cnt", pkt_cnt[p], sent_tally[p]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
